// File: rtl/task2_pkg.sv
// Shared constants and types for the task2 framebuffer fill.
package task2_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = $clog2(SCREEN_W);
  localparam int unsigned Y_W      = $clog2(SCREEN_H);

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/task2_fill_fillscreen_core.sv
// Fill FSM and column-major pixel counters; plots one pixel per cycle.
module fillscreen_core
  import task2_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  fill_state_t    state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next state: rows advance fastest, column steps when a row scan wraps.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: begin
        if (y_q < Y_LAST) begin
          y_d = y_q + 1'b1;
        end else begin
          y_d = '0;
          if (x_q < X_LAST) x_d = x_q + 1'b1;
          else              state_d = DONE;
        end
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Plot interface is combinational from the registers so reset kills the strobe at once.
  always_comb begin
    vga_plot   = (state_q == FILL);
    done       = (state_q == DONE);
    vga_x      = x_q;
    vga_y      = y_q;
    vga_colour = x_q[COLOUR_W-1:0];
  end

endmodule

// File: rtl/task2_fill.sv
// Board top: maps pins to the fill core and blanks HEX displays.
// Define VGA_ADAPTER_EN to drive the VGA DAC pins from a vga_adapter instance.
module task2_fill
  import task2_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_CLK,
  output logic [7:0] VGA_X,
  output logic [6:0] VGA_Y,
  output logic [2:0] VGA_COLOUR,
  output logic       VGA_PLOT
);

  logic done;
  logic unused_inputs;

  assign unused_inputs = &{1'b0, SW, KEY[2:0]};

  fillscreen_core u_core (
    .clk        (CLOCK_50),
    .rst_n      (KEY[3]),
    .start      (1'b1),
    .done       (done),
    .vga_x      (VGA_X),
    .vga_y      (VGA_Y),
    .vga_colour (VGA_COLOUR),
    .vga_plot   (VGA_PLOT)
  );

  // Status LEDs and blank (active-low) seven-segment displays.
  always_comb begin
    LEDR = {9'd0, done};
    HEX0 = '1;
    HEX1 = '1;
    HEX2 = '1;
    HEX3 = '1;
    HEX4 = '1;
    HEX5 = '1;
  end

`ifdef VGA_ADAPTER_EN
  vga_adapter #(
    .RESOLUTION              ("160x120"),
    .MONOCHROME              ("FALSE"),
    .BITS_PER_COLOUR_CHANNEL (1)
  ) u_vga (
    .resetn  (KEY[3]),
    .clock   (CLOCK_50),
    .colour  (VGA_COLOUR),
    .x       (VGA_X),
    .y       (VGA_Y),
    .plot    (VGA_PLOT),
    .VGA_R   (VGA_R),
    .VGA_G   (VGA_G),
    .VGA_B   (VGA_B),
    .VGA_HS  (VGA_HS),
    .VGA_VS  (VGA_VS),
    .VGA_CLK (VGA_CLK)
  );
`else
  // No adapter: DAC and sync pins held low.
  always_comb begin
    VGA_R   = '0;
    VGA_G   = '0;
    VGA_B   = '0;
    VGA_HS  = 1'b0;
    VGA_VS  = 1'b0;
    VGA_CLK = 1'b0;
  end
`endif

endmodule

// File: tb/tb_task2_fill.sv
// Scoreboard bench for task2_fill: expected pixel stream queued at start, monitor pops on each plot.
module tb_task2_fill;

  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       key3 = 1'b0;
  logic [2:0] key_lo = 3'd0;
  logic [3:0] KEY;
  logic [9:0] SW = 10'd0;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       VGA_HS, VGA_VS, VGA_CLK;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOUR;
  logic       VGA_PLOT;

  assign KEY = {key3, key_lo};

  always #5 clk = ~clk;

  task2_fill dut (
    .CLOCK_50   (clk),
    .KEY        (KEY),
    .SW         (SW),
    .LEDR       (LEDR),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3),
    .HEX4       (HEX4),
    .HEX5       (HEX5),
    .VGA_R      (VGA_R),
    .VGA_G      (VGA_G),
    .VGA_B      (VGA_B),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_CLK    (VGA_CLK),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_COLOUR (VGA_COLOUR),
    .VGA_PLOT   (VGA_PLOT)
  );

  typedef struct { int x; int y; int c; } pix_t;

  pix_t exp_q[$];
  int   cov [W][H];
  int   plot_cnt = 0;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   last_x = -1, last_y = -1, last_c = -1;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pixel k of a column-major scan.
  task automatic push_expected();
    pix_t p;
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin
      p.x = k / H;
      p.y = k % H;
      p.c = p.x % 8;
      exp_q.push_back(p);
    end
  endtask

  task automatic clear_cov();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        cov[x][y] = 0;
    plot_cnt = 0;
  endtask

  // Unused inputs toggle randomly throughout; they must not disturb anything.
  always @(posedge clk) begin
    #2;
    SW     = 10'($urandom);
    key_lo = 3'($urandom);
  end

  // Monitor: every plotted pixel is popped and compared against the model.
  always @(negedge clk) begin
    if (VGA_PLOT === 1'b1) begin
      pix_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_plot", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (VGA_X != 8'(e.x) || VGA_Y != 7'(e.y) || VGA_COLOUR != 3'(e.c)) begin
          chk_cnt++;
          $display("FAIL pixel#%0d: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                   plot_cnt, VGA_X, VGA_Y, VGA_COLOUR, e.x, e.y, e.c);
        end else begin
          chk_cnt++;
          pass_cnt++;
        end
      end
      if (VGA_X > 8'd159 || VGA_Y > 7'd119) check("range", 1, 0);
      else cov[VGA_X][VGA_Y]++;
      last_x = int'(VGA_X);
      last_y = int'(VGA_Y);
      last_c = int'(VGA_COLOUR);
      plot_cnt++;
    end
  end

  task automatic hold_reset(input int cycles);
    key3 = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_plot", int'(VGA_PLOT), 0);
    check("reset_ledr", int'(LEDR), 0);
    check("reset_hex", int'({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5}), int'({6{7'h7F}}));
    check("reset_xy", int'({VGA_X, VGA_Y, VGA_COLOUR}), 0);
  endtask

  task automatic release_and_check_start();
    int seen;
    clear_cov();
    push_expected();
    key3 = 1'b1;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (VGA_PLOT) seen = 1;
    end
    check("start_plot", int'(VGA_PLOT), 1);
    check("start_xyc", int'({VGA_X, VGA_Y, VGA_COLOUR}), 0);
  endtask

  task automatic wait_plots(input int target);
    int budget;
    budget = NPIX + 50;
    while (plot_cnt < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("plot_count_reached", int'(plot_cnt >= target), 1);
  endtask

  initial begin
    int hold_len;
    int bad_cov;
    int hold_ok;

    // Run 1: reset, start, abort mid-fill.
    hold_reset(5);
    check("vga_dac_idle", int'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_CLK}), 0);
    release_and_check_start();
    wait_plots(121);
    check("wrap_0_119_to_1_0", cov[0][119] + cov[1][0], 2);
    wait_plots(5000);
    #2;
    key3 = 1'b0;
    #1;
    check("abort_plot_async", int'(VGA_PLOT), 0);
    check("abort_ledr", int'(LEDR[0]), 0);
    check("abort_count", plot_cnt, 5000);
    hold_len = int'($urandom_range(2, 10));
    hold_reset(hold_len);

    // Run 2: full fill from (0,0).
    release_and_check_start();
    wait_plots(NPIX);
    @(negedge clk);
    #1;
    check("total_plots", plot_cnt, NPIX);
    check("last_pixel", last_x * 1000 + last_y * 10 + last_c, 159 * 1000 + 119 * 10 + 7);
    check("queue_drained", exp_q.size(), 0);
    check("done_led", int'(LEDR), 1);
    check("done_plot", int'(VGA_PLOT), 0);
    hold_ok = 1;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (LEDR !== 10'd1 || VGA_PLOT !== 1'b0) hold_ok = 0;
    end
    check("done_hold_100", hold_ok, 1);
    check("stripe_8_5", cov[8][5], 1);
    check("stripe_13_0", cov[13][0], 1);
    bad_cov = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        if (cov[x][y] != 1) bad_cov++;
    check("coverage_once", bad_cov, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
